// File: rtl/bit_serial_adder.sv
// ============================================================================
// Module      : bit_serial_adder
// Description : LSB-first bit-serial adder with one full-adder slice
//               and an IDLE/SHIFT/DONE sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bit_serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             sum_bit,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] c_last = CW'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_next_state;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_sum_bit;

  // Full-adder slice: two half adders whose carries are ORed.
  logic w_ha0_s, w_ha0_c, w_ha1_s, w_ha1_c, w_carry;
  assign w_ha0_s = r_a_sh[0] ^ r_b_sh[0];
  assign w_ha0_c = r_a_sh[0] & r_b_sh[0];
  assign w_ha1_s = w_ha0_s ^ r_carry;
  assign w_ha1_c = w_ha0_s & r_carry;
  assign w_carry = w_ha0_c | w_ha1_c;

  logic w_accept;
  logic w_last;
  assign w_accept = (r_state == S_IDLE) && start;
  assign w_last   = (r_state == S_SHIFT) && (r_cnt == c_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_SHIFT;
      S_SHIFT: if (r_cnt == c_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (r_state == S_SHIFT);
    done = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a_sh    <= '0;
      r_b_sh    <= '0;
      r_carry   <= 1'b0;
      r_cnt     <= '0;
      r_sum     <= '0;
      r_cout    <= 1'b0;
      r_sum_bit <= 1'b0;
    end else if (w_accept) begin
      r_a_sh  <= a;
      r_b_sh  <= b;
      r_carry <= cin;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (r_state == S_SHIFT) begin
      r_sum[r_cnt] <= w_ha1_s;
      r_sum_bit    <= w_ha1_s;
      r_carry      <= w_carry;
      r_a_sh       <= {1'b0, r_a_sh[WIDTH-1:1]};
      r_b_sh       <= {1'b0, r_b_sh[WIDTH-1:1]};
      r_cnt        <= r_cnt + CW'(1);
      if (w_last) r_cout <= w_carry;
    end
  end

  assign sum     = r_sum;
  assign cout    = r_cout;
  assign sum_bit = r_sum_bit;

endmodule

`default_nettype wire

// File: tb/tb_bit_serial_adder.sv
// ============================================================================
// Module      : tb_bit_serial_adder
// Description : Directed-vector and random self-checking bench for bit_serial_adder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bit_serial_adder;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic       cin;
  logic [7:0] sum;
  logic       cout;
  logic       sum_bit;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;

  bit_serial_adder #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .cin(cin),
    .sum(sum), .cout(cout), .sum_bit(sum_bit), .busy(busy), .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic [7:0] exp_sum;
    logic       exp_cout;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one operation; operands are scrambled right after acceptance.
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tc,
                        output logic [7:0] rs, output logic rc, output int dk,
                        output int bc, output logic [7:0] sb);
    @(negedge clk);
    a = ta; b = tb_v; cin = tc; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = 8'($urandom); b = 8'($urandom); cin = 1'($urandom);
    dk = -1; bc = 0; sb = '0; rs = '0; rc = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (busy) bc++;
      if (k >= 2 && k <= 9) sb[k-2] = sum_bit;
      if (done) begin
        dk = k; rs = sum; rc = cout;
        break;
      end
    end
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
  endtask

  initial begin
    logic [7:0] rs, sb;
    logic       rc;
    logic [8:0] full;
    logic [7:0] ra, rb;
    logic       rcn;
    int         dk, bc, npulse, first_k, second_k, ndone;

    vecs[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
    vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
    vecs[2] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};
    vecs[3] = '{8'h3C, 8'h0F, 1'b0, 8'h4B, 1'b0};
    vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
    vecs[6] = '{8'h01, 8'h01, 1'b1, 8'h03, 1'b0};
    vecs[7] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    @(negedge clk);
    chk("reset_sum",  {24'd0, sum}, 32'd0);
    chk("reset_cout", {31'd0, cout}, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, dk, bc, sb);
      chk("vec_sum",      {24'd0, rs}, {24'd0, vecs[i].exp_sum});
      chk("vec_cout",     {31'd0, rc}, {31'd0, vecs[i].exp_cout});
      chk("vec_done_lat", dk, 9);
      chk("vec_busy_cyc", bc, 8);
      chk("vec_sum_bits", {24'd0, sb}, {24'd0, vecs[i].exp_sum});
    end

    // Start raised mid-operation and held through DONE.
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    npulse = 0; first_k = -1; second_k = -1;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (k == 3) begin
        start = 1'b1; a = 8'hFF; b = 8'hFF; cin = 1'b0;
      end
      if (done) begin
        npulse++;
        if (first_k < 0) begin
          first_k = k;
          chk("b2b_first_sum",  {24'd0, sum}, 32'h46);
          chk("b2b_first_cout", {31'd0, cout}, 32'd0);
        end else begin
          second_k = k;
          chk("b2b_second_sum",  {24'd0, sum}, 32'hFE);
          chk("b2b_second_cout", {31'd0, cout}, 32'd1);
          break;
        end
      end
      if (first_k > 0 && k == first_k + 2) start = 1'b0;
    end
    start = 1'b0;
    chk("b2b_first_done_k", first_k, 9);
    chk("b2b_period",       second_k - first_k, 10);
    chk("b2b_pulses",       npulse, 2);
    @(negedge clk);
    @(negedge clk);

    // Asynchronous reset in the middle of SHIFT.
    @(negedge clk);
    a = 8'hFF; b = 8'h00; cin = 1'b0; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int k = 1; k <= 6; k++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_sum",     {24'd0, sum}, 32'd0);
    chk("async_rst_cout",    {31'd0, cout}, 32'd0);
    chk("async_rst_sum_bit", {31'd0, sum_bit}, 32'd0);
    chk("async_rst_busy",    {31'd0, busy}, 32'd0);
    chk("async_rst_done",    {31'd0, done}, 32'd0);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      if (k == 2) rst_n = 1'b1;
      if (done) ndone++;
    end
    chk("rst_no_done", ndone, 0);
    run_op(8'h3C, 8'h0F, 1'b0, rs, rc, dk, bc, sb);
    chk("post_rst_sum",  {24'd0, rs}, 32'h4B);
    chk("post_rst_cout", {31'd0, rc}, 32'd0);
    chk("post_rst_lat",  dk, 9);

    for (int n = 0; n < 200; n++) begin
      ra = 8'($urandom); rb = 8'($urandom); rcn = 1'($urandom);
      full = {1'b0, ra} + {1'b0, rb} + {8'd0, rcn};
      run_op(ra, rb, rcn, rs, rc, dk, bc, sb);
      chk("rand_result", {23'd0, rc, rs}, {23'd0, full});
      chk("rand_lat",    dk, 9);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/bit_serial_adder.md
BIT_SERIAL_ADDER -- requirements
Module: bit_serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand and sum width in bits; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 start  input  1  request to begin an addition; sampled only in IDLE.
REQ-005 a  input  WIDTH  operand A; captured on the accepting edge.
REQ-006 b  input  WIDTH  operand B; captured on the accepting edge.
REQ-007 cin  input  1  carry-in; captured on the accepting edge.
REQ-008 sum  output  WIDTH  result register, LSB-first assembly; holds its last value until the next acceptance.
REQ-009 cout  output  1  final carry-out; valid when done=1 and held until the next acceptance.
REQ-010 sum_bit  output  1  registered serial sum bit produced on the most recent SHIFT edge.
REQ-011 busy  output  1  high while the FSM is in SHIFT.
REQ-012 done  output  1  one-cycle completion pulse.

Function
REQ-013 The FSM SHALL have three states: IDLE, SHIFT and DONE; encoding is free.
REQ-014 IDLE->SHIFT on an edge with start=1; on that edge: a/b load shift registers, cin loads the carry flop, bit counter=0, sum=0, cout=0.
REQ-015 In SHIFT, each edge SHALL add a_sh[0] + b_sh[0] + carry with one full-adder slice (sum = x^y^z, carry = xy|xz|yz), built structurally from two half adders plus an OR.
REQ-016 Each SHIFT edge: sum bit -> sum[counter] and sum_bit; carry flop <- new carry; a_sh and b_sh shift right by 1 with zero fill; counter +1.
REQ-017 On the SHIFT edge that writes bit WIDTH-1: state -> DONE; cout <- the new carry.
REQ-018 DONE -> IDLE unconditionally on the next edge; done=1 only while in DONE.
REQ-019 Latency: done is high in the cycle after the WIDTH-th edge following the accepting edge, so exactly WIDTH+1 edges from acceptance to the done cycle.
REQ-020 start in SHIFT or DONE SHALL be ignored, with no queueing. A start held high through DONE is accepted on the first IDLE edge, giving a WIDTH+2 edge period for back-to-back operations.
REQ-021 a, b and cin changing after acceptance SHALL NOT affect the result in progress.
REQ-022 Arithmetic: {cout,sum} = a + b + cin, unsigned, modulo 2^(WIDTH+1); overflow is reported only through cout.
REQ-023 busy = (state==SHIFT) and done = (state==DONE); both SHALL be decoded from state with no combinational path from inputs.

Reset
REQ-024 rst_n=0 SHALL immediately, without waiting for a clock edge, force: state=IDLE, sum=0, cout=0, sum_bit=0, busy=0, done=0, carry flop=0, counter=0, shift registers=0.
REQ-025 Reset asserted mid-SHIFT SHALL abort the operation; no done pulse is emitted and the partial sum is cleared.
REQ-026 After rst_n rises, the first edge with start=1 SHALL be accepted normally.

Verification (WIDTH=8)
REQ-027 a=0x00, b=0x00, cin=0, pulse start -> busy for 8 cycles, done 9 edges after acceptance, sum=0x00, cout=0.
REQ-028 a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1; sum_bit sequence is 0 for all 8 SHIFT cycles.
REQ-029 a=0xA5, b=0x5A, cin=1 -> sum=0x00, cout=1; a=0x3C, b=0x0F, cin=0 -> sum=0x4B, cout=0.
REQ-030 Start a=0x12, b=0x34, then drive start=1 with a=0xFF, b=0xFF at SHIFT cycle 3 -> result 0x46, cout=0, exactly one done pulse. With start held, the second operation begins on the IDLE edge after DONE and gives 0xFE, cout=1.
REQ-031 Assert rst_n=0 mid-SHIFT (after bit 4) -> all outputs read 0 asynchronously and no done pulse. A new start after release then completes correctly.
REQ-032 Self-checking: random a, b, cin over at least 200 operations compared against a+b+cin, with each done pulse checked to last exactly one cycle.
